// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, instruction field layout, opcodes,
// the ID/EX bundle type and opcode classification helpers.
package pipe_pkg;

    localparam int DATA_W    = 8;
    localparam int NREG      = 16;
    localparam int REG_IDX_W = 4;
    localparam int INSTR_W   = 16;
    localparam int OP_W      = 4;

    localparam int OP_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS1_LSB = 4;
    localparam int RS2_LSB = 0;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OP_W-1:0] OP_AND  = 4'h3;
    localparam logic [OP_W-1:0] OP_OR   = 4'h4;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OP_W-1:0] OP_ADDI = 4'h6;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h7;
    localparam logic [OP_W-1:0] OP_LD   = 4'h8;
    localparam logic [OP_W-1:0] OP_ST   = 4'h9;
    localparam logic [OP_W-1:0] OP_BEQZ = 4'hA;
    localparam logic [OP_W-1:0] OP_JMP  = 4'hB;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef struct packed {
        logic                 valid;
        logic [OP_W-1:0]      op;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic                 wr_en;
        logic                 illegal;
    } id_bundle_t;

    function automatic logic op_reads_rs1(input logic [OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_ADDI, OP_LD, OP_ST, OP_BEQZ: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic op_reads_rs2(input logic [OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: r = 1'b1;
            default:                               r = 1'b0;
        endcase
        return r;
    endfunction

    // ST sources its store data from the rd field rather than rs2.
    function automatic logic op_reads_rd(input logic [OP_W-1:0] op);
        return (op == OP_ST);
    endfunction

    function automatic logic op_writes_rd(input logic [OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_LD);
    endfunction

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op < 4'hC) || (op == OP_HALT);
    endfunction

    function automatic logic [DATA_W-1:0] sext_imm4(input logic [3:0] imm);
        return {{(DATA_W-4){imm[3]}}, imm};
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 16x8 register file: two combinational read ports, one posedge write port,
// asynchronous active-low clear. Same-cycle bypass is handled by the caller.
module regfile_2r1w
    import pipe_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [REG_IDX_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic [REG_IDX_W-1:0] raddr_a_i,
    input  logic [REG_IDX_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0]    rdata_a_o,
    output logic [DATA_W-1:0]    rdata_b_o
);

    logic [DATA_W-1:0] mem_q [NREG];

    // Storage array with asynchronous clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: field/control decode, bypassed operand read,
// load-use stall, flush, sticky HALT, and a registered ID/EX bundle.
module decode_stage
    import pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [INSTR_W-1:0]   if_instr,
    output logic                 id_stall,
    input  logic                 flush,
    input  logic                 ex_fwd_en,
    input  logic [REG_IDX_W-1:0] ex_fwd_rd,
    input  logic [DATA_W-1:0]    ex_fwd_data,
    input  logic                 ex_is_load,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 id_valid,
    output logic [OP_W-1:0]      id_op,
    output logic [REG_IDX_W-1:0] id_rd,
    output logic [DATA_W-1:0]    id_a,
    output logic [DATA_W-1:0]    id_b,
    output logic                 id_wr_en,
    output logic                 id_illegal
);

    logic [OP_W-1:0]      op_s;
    logic [REG_IDX_W-1:0] rd_s;
    logic [REG_IDX_W-1:0] rs1_s;
    logic [REG_IDX_W-1:0] rs2_s;
    logic [REG_IDX_W-1:0] rb_idx_s;
    logic [DATA_W-1:0]    imm8_s;
    logic [DATA_W-1:0]    rf_a_s;
    logic [DATA_W-1:0]    rf_b_s;
    logic [DATA_W-1:0]    opa_s;
    logic [DATA_W-1:0]    rb_val_s;
    logic [DATA_W-1:0]    opb_s;
    logic                 ex_ok_s;
    logic                 load_hit_s;
    logic                 load_stall_s;
    logic                 issue_s;
    logic                 halted_q;
    id_bundle_t           bundle_d;
    id_bundle_t           bundle_q;

    assign op_s     = if_instr[OP_LSB  +: OP_W];
    assign rd_s     = if_instr[RD_LSB  +: REG_IDX_W];
    assign rs1_s    = if_instr[RS1_LSB +: REG_IDX_W];
    assign rs2_s    = if_instr[RS2_LSB +: REG_IDX_W];
    assign imm8_s   = if_instr[DATA_W-1:0];
    assign rb_idx_s = op_reads_rd(op_s) ? rd_s : rs2_s;

    regfile_2r1w u_regfile (
        .clk_i     (clk),
        .rst_ni    (rst),
        .we_i      (wb_en),
        .waddr_i   (wb_rd),
        .wdata_i   (wb_data),
        .raddr_a_i (rs1_s),
        .raddr_b_i (rb_idx_s),
        .rdata_a_o (rf_a_s),
        .rdata_b_o (rf_b_s)
    );

    // A load's result is not ready in execute, so it never feeds the bypass.
    assign ex_ok_s = ex_fwd_en & ~ex_is_load;

    assign load_hit_s = (op_reads_rs1(op_s) && (ex_fwd_rd == rs1_s)) ||
                        (op_reads_rs2(op_s) && (ex_fwd_rd == rs2_s)) ||
                        (op_reads_rd(op_s)  && (ex_fwd_rd == rd_s));

    assign load_stall_s = if_valid & ex_is_load & load_hit_s & ~flush & ~halted_q;
    assign issue_s      = if_valid & ~flush & ~halted_q & ~load_stall_s;
    assign id_stall     = rst & (halted_q | load_stall_s);

    // Operand A bypass: execute, then writeback, then register file
    always_comb begin
        opa_s = '0;
        if (ex_ok_s && (ex_fwd_rd == rs1_s)) begin
            opa_s = ex_fwd_data;
        end else if (wb_en && (wb_rd == rs1_s)) begin
            opa_s = wb_data;
        end else begin
            opa_s = rf_a_s;
        end
    end

    // Second register read bypass (rs2, or rd for stores)
    always_comb begin
        rb_val_s = '0;
        if (ex_ok_s && (ex_fwd_rd == rb_idx_s)) begin
            rb_val_s = ex_fwd_data;
        end else if (wb_en && (wb_rd == rb_idx_s)) begin
            rb_val_s = wb_data;
        end else begin
            rb_val_s = rf_b_s;
        end
    end

    // Operand B source select by opcode
    always_comb begin
        opb_s = '0;
        case (op_s)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ST: opb_s = rb_val_s;
            OP_ADDI:                                      opb_s = sext_imm4(if_instr[3:0]);
            OP_LDI, OP_BEQZ, OP_JMP:                      opb_s = imm8_s;
            default:                                      opb_s = '0;
        endcase
    end

    // Next ID/EX bundle; bubbles and illegal ops carry zeroed fields
    always_comb begin
        bundle_d = '0;
        if (issue_s) begin
            bundle_d.valid = 1'b1;
            if (op_is_legal(op_s)) begin
                bundle_d.op    = op_s;
                bundle_d.rd    = rd_s;
                bundle_d.a     = opa_s;
                bundle_d.b     = opb_s;
                bundle_d.wr_en = op_writes_rd(op_s);
            end else begin
                bundle_d.illegal = 1'b1;
            end
        end else begin
            bundle_d = '0;
        end
    end

    // ID/EX pipeline register and sticky halt flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bundle_q <= '0;
            halted_q <= 1'b0;
        end else begin
            bundle_q <= bundle_d;
            halted_q <= halted_q | (issue_s & (op_s == OP_HALT));
        end
    end

    assign id_valid   = bundle_q.valid;
    assign id_op      = bundle_q.op;
    assign id_rd      = bundle_q.rd;
    assign id_a       = bundle_q.a;
    assign id_b       = bundle_q.b;
    assign id_wr_en   = bundle_q.wr_en;
    assign id_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed table-driven bench for decode_stage plus hand-written reset,
// reset-mid-stall and HALT sequences.
module tb_decode_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       if_valid = 1'b0;
    logic [15:0] if_instr = 16'h0000;
    logic       id_stall;
    logic       flush = 1'b0;
    logic       ex_fwd_en = 1'b0;
    logic [3:0] ex_fwd_rd = 4'h0;
    logic [7:0] ex_fwd_data = 8'h00;
    logic       ex_is_load = 1'b0;
    logic       wb_en = 1'b0;
    logic [3:0] wb_rd = 4'h0;
    logic [7:0] wb_data = 8'h00;
    logic       id_valid;
    logic [3:0] id_op;
    logic [3:0] id_rd;
    logic [7:0] id_a;
    logic [7:0] id_b;
    logic       id_wr_en;
    logic       id_illegal;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
        .id_stall(id_stall), .flush(flush), .ex_fwd_en(ex_fwd_en),
        .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data), .ex_is_load(ex_is_load),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .id_valid(id_valid),
        .id_op(id_op), .id_rd(id_rd), .id_a(id_a), .id_b(id_b),
        .id_wr_en(id_wr_en), .id_illegal(id_illegal)
    );

    typedef struct packed {
        logic       v;
        logic [15:0] ins;
        logic       fl;
        logic       exen;
        logic [3:0] exrd;
        logic [7:0] exd;
        logic       exld;
        logic       wben;
        logic [3:0] wbrd;
        logic [7:0] wbd;
        logic       e_stall;
        logic       e_valid;
        logic [3:0] e_op;
        logic [3:0] e_rd;
        logic [7:0] e_a;
        logic [7:0] e_b;
        logic       e_wr;
        logic       e_ill;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        if_valid = t.v;   if_instr = t.ins;  flush = t.fl;
        ex_fwd_en = t.exen; ex_fwd_rd = t.exrd; ex_fwd_data = t.exd; ex_is_load = t.exld;
        wb_en = t.wben;   wb_rd = t.wbrd;    wb_data = t.wbd;
    endtask

    task automatic check_bundle(input string tag, input vec_t t);
        chk({tag, ".valid"},   {15'd0, id_valid},   {15'd0, t.e_valid});
        chk({tag, ".op"},      {12'd0, id_op},      {12'd0, t.e_op});
        chk({tag, ".rd"},      {12'd0, id_rd},      {12'd0, t.e_rd});
        chk({tag, ".a"},       {8'd0, id_a},        {8'd0, t.e_a});
        chk({tag, ".b"},       {8'd0, id_b},        {8'd0, t.e_b});
        chk({tag, ".wr_en"},   {15'd0, id_wr_en},   {15'd0, t.e_wr});
        chk({tag, ".illegal"}, {15'd0, id_illegal}, {15'd0, t.e_ill});
    endtask

    // Drive one cycle: check combinational stall before the edge, bundle after it.
    task automatic run_vec(input string tag, input vec_t t);
        apply(t);
        #2;
        chk({tag, ".stall"}, {15'd0, id_stall}, {15'd0, t.e_stall});
        @(posedge clk);
        #1;
        check_bundle(tag, t);
    endtask

    vec_t hv;
    vec_t zero_v;

    initial begin
        //          v     ins       fl    exen  exrd  exd    exld  wben  wbrd  wbd    | stall valid op   rd    a      b      wr    ill
        vecs[0]  = '{1'b1, 16'h1132, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h3, 8'h5A, 1'b0, 1'b1, 4'h1, 4'h1, 8'h5A, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 16'h643F, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h2, 8'h33, 1'b0, 1'b1, 4'h6, 4'h4, 8'h5A, 8'hFF, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 16'h2422, 1'b0, 1'b1, 4'h2, 8'h11, 1'b0, 1'b1, 4'h2, 8'h77, 1'b0, 1'b1, 4'h2, 4'h4, 8'h11, 8'h11, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 16'h3523, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h3, 4'h5, 8'h77, 8'h5A, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 16'h77A5, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h7, 4'h7, 8'h00, 8'hA5, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 16'h9230, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h9, 4'h2, 8'h5A, 8'h77, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 16'h8830, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h8, 4'h8, 8'h5A, 8'h00, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 16'hA0C4, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'hA, 4'h0, 8'h00, 8'hC4, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 16'hB035, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'hB, 4'h0, 8'h5A, 8'h35, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 16'hC123, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 16'hE000, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 16'h1651, 1'b0, 1'b1, 4'h5, 8'h99, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 16'h1651, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h1, 4'h6, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 16'h9310, 1'b0, 1'b0, 4'h3, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 16'h6431, 1'b0, 1'b1, 4'h1, 8'h44, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h6, 4'h4, 8'h5A, 8'h01, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 16'h1651, 1'b1, 1'b1, 4'h5, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 16'h1651, 1'b0, 1'b1, 4'h5, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 16'h1132, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 16'h0000, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0};
        zero_v = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall", {15'd0, id_stall}, 16'd0);
        check_bundle("reset", zero_v);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset mid-stall: load r9, read it back through a bundle, then stall on it
        hv = '{1'b1, 16'h1199, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h9, 8'h42, 1'b0, 1'b1, 4'h1, 4'h1, 8'h42, 8'h42, 1'b1, 1'b0};
        run_vec("rst_pre", hv);
        hv = '{1'b1, 16'h1199, 1'b0, 1'b1, 4'h9, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h1, 4'h1, 8'h42, 8'h42, 1'b1, 1'b0};
        apply(hv);
        #2;
        chk("rst_stall.stall", {15'd0, id_stall}, 16'd1);
        rst = 1'b0;
        #1;
        chk("rst_mid.stall", {15'd0, id_stall}, 16'd0);
        check_bundle("rst_mid", zero_v);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        hv = '{1'b1, 16'h1199, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h1, 4'h1, 8'h00, 8'h00, 1'b1, 1'b0};
        run_vec("rst_post", hv);

        // HALT issues once, then stall is held and bundles are bubbles
        hv = '{1'b1, 16'hF000, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'hF, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0};
        run_vec("halt_issue", hv);
        hv = '{1'b1, 16'h1132, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0};
        run_vec("halted1", hv);
        run_vec("halted2", hv);
        hv.fl = 1'b1;
        run_vec("halted_flush", hv);
        rst = 1'b0;
        #2;
        chk("halt_rst.stall", {15'd0, id_stall}, 16'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        hv = '{1'b1, 16'h1132, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h1, 4'h1, 8'h00, 8'h00, 1'b1, 1'b0};
        run_vec("after_halt", hv);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
